// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 host receiver.
package ps2_pkg;

  // Scancode prefixes merged into key events
  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_REL = 8'hF0;

  // start + 8 data + parity + stop
  localparam int PS2_FRAME_BITS = 11;

  // Frame receiver states; the bit counter refines SHIFT (counts 1..9)
  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    STOP
  } ps2_state_e;

  // Odd parity holds when data plus parity bit carry an odd number of ones
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_rx_filter.sv
// Synchroniser and glitch filter for one PS/2 line.
// The filtered level only moves after FILTER consecutive synchronised
// samples that all disagree with it.
module ps2_rx_filter #(
  parameter int FILTER = 4
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic line_in,
  output logic line_out
);

  localparam logic [3:0] RUN_LAST = 4'(FILTER - 1);

  logic [1:0] sync_q;
  logic [3:0] run_cnt;

  // Two-stage synchroniser feeding a run-length counter that gates level changes
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      // NOTE: synchroniser and level reset to the idle-high value so leaving reset never fakes a falling edge.
      sync_q   <= 2'b11;
      run_cnt  <= '0;
      line_out <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so each flop samples pre-edge values.
      sync_q <= {sync_q[0], line_in};
      if (sync_q[1] == line_out) begin
        run_cnt <= '0;
      end else if (run_cnt == RUN_LAST) begin
        line_out <= sync_q[1];
        run_cnt  <= '0;
      end else begin
        run_cnt <= run_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_rx.sv
// Core-side PS/2 receiver: filters the clock/data pair, deserialises
// 11-bit odd-parity frames on falling clock edges, and folds E0/F0
// prefixes into key events for the keyboard matrix logic.
module ps2_host_rx
  import ps2_pkg::*;
#(
  parameter int FILTER  = 4,
  parameter int TIMEOUT = 8191
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       err_parity,
  output logic       err_frame,
  output logic       err_timeout,
  output logic       busy,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_pressed,
  output logic       key_strobe
);

  localparam int              WD_W       = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LIMIT   = WD_W'(TIMEOUT);
  localparam logic [WD_W-1:0] WD_ONE     = WD_W'(1);
  localparam logic [3:0]      CNT_PARITY = 4'(PS2_FRAME_BITS - 2);

  logic            clk_f;
  logic            data_f;
  logic            clk_f_d;
  logic            fall;
  ps2_state_e      state;
  logic [3:0]      bit_cnt;
  logic [7:0]      shift_reg;
  logic            par_bit;
  logic [WD_W-1:0] wdog;
  logic            ext_flag;
  logic            rel_flag;

  ps2_rx_filter #(.FILTER(FILTER)) u_clk_filter (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .line_in  (ps2_clk),
    .line_out (clk_f)
  );

  ps2_rx_filter #(.FILTER(FILTER)) u_data_filter (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .line_in  (ps2_data),
    .line_out (data_f)
  );

  // Falling edge of the filtered clock is the only sampling event
  assign fall = clk_f_d & ~clk_f;
  assign busy = (bit_cnt != 4'd0);

  // Frame receiver: bit counter, shift register, watchdog and result strobes.
  // The watchdog reads 1 on the cycle after an edge, so it equals the number
  // of cycles elapsed since the edge cycle.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      clk_f_d     <= 1'b1;
      state       <= IDLE;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      par_bit     <= 1'b0;
      wdog        <= '0;
      rx_byte     <= '0;
      rx_valid    <= 1'b0;
      err_parity  <= 1'b0;
      err_frame   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      clk_f_d     <= clk_f;
      // NOTE: strobes default low first; only the event paths below raise them for one cycle.
      rx_valid    <= 1'b0;
      err_parity  <= 1'b0;
      err_frame   <= 1'b0;
      err_timeout <= 1'b0;

      if (busy && (wdog == WD_LIMIT)) begin
        // Stalled frame: abort and discard the partial byte
        err_timeout <= 1'b1;
        state       <= IDLE;
        bit_cnt     <= '0;
        shift_reg   <= '0;
        par_bit     <= 1'b0;
        wdog        <= '0;
      end else if (fall) begin
        case (state)
          IDLE: begin
            if (!data_f) begin
              state   <= SHIFT;
              bit_cnt <= 4'd1;
              wdog    <= WD_ONE;
            end else begin
              err_frame <= 1'b1;
            end
          end
          SHIFT: begin
            if (bit_cnt == CNT_PARITY) begin
              par_bit <= data_f;
              state   <= STOP;
            end else begin
              shift_reg <= {data_f, shift_reg[7:1]};
            end
            bit_cnt <= bit_cnt + 4'd1;
            wdog    <= WD_ONE;
          end
          STOP: begin
            state   <= IDLE;
            bit_cnt <= '0;
            wdog    <= '0;
            if (!data_f) begin
              err_frame <= 1'b1;
            end else if (!odd_parity_ok(shift_reg, par_bit)) begin
              err_parity <= 1'b1;
            end else begin
              rx_byte  <= shift_reg;
              rx_valid <= 1'b1;
            end
          end
          default: begin
            state   <= IDLE;
            bit_cnt <= '0;
            wdog    <= '0;
          end
        endcase
      end else if (busy) begin
        wdog <= wdog + WD_ONE;
      end
    end
  end

  // Scancode layer: prefixes set sticky flags, any other byte emits a key event
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      ext_flag    <= 1'b0;
      rel_flag    <= 1'b0;
      key_code    <= '0;
      key_ext     <= 1'b0;
      key_pressed <= 1'b0;
      key_strobe  <= 1'b0;
    end else begin
      key_strobe <= 1'b0;
      if (rx_valid) begin
        if (rx_byte == PS2_PREFIX_EXT) begin
          ext_flag <= 1'b1;
        end else if (rx_byte == PS2_PREFIX_REL) begin
          rel_flag <= 1'b1;
        end else begin
          key_code    <= rx_byte;
          key_ext     <= ext_flag;
          key_pressed <= ~rel_flag;
          key_strobe  <= 1'b1;
          ext_flag    <= 1'b0;
          rel_flag    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_rx.sv
// Self-checking bench for ps2_host_rx: table-driven frames, hand-written
// corner sequences and randomized frames against a frame-level model.
`timescale 1ns/1ps
module tb_ps2_host_rx;

  localparam int FILTER  = 4;
  localparam int TIMEOUT = 2100;
  // raw edge -> 2 sync stages -> FILTER samples -> registered strobe
  localparam int LAT     = 3 + FILTER;

  logic       clk_sys  = 1'b0;
  logic       reset_n  = 1'b0;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_valid, err_parity, err_frame, err_timeout, busy;
  logic [7:0] key_code;
  logic       key_ext, key_pressed, key_strobe;

  ps2_host_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .err_parity  (err_parity),
    .err_frame   (err_frame),
    .err_timeout (err_timeout),
    .busy        (busy),
    .key_code    (key_code),
    .key_ext     (key_ext),
    .key_pressed (key_pressed),
    .key_strobe  (key_strobe)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  typedef enum int {R_VALID, R_PARITY, R_FRAME, R_TIMEOUT} res_e;
  typedef struct { res_e kind; logic [7:0] val; int cyc; } rx_ev_t;
  typedef struct { logic [7:0] code; logic ext; logic pressed; int cyc; } key_ev_t;
  typedef struct {
    logic [7:0] data; logic par; logic stop; int div;
    res_e kind; logic [7:0] rx; logic key; logic [7:0] code; logic ext; logic pressed;
  } vec_t;

  rx_ev_t  obs_rx[$];
  key_ev_t obs_key[$];

  // Observe every strobe away from the active edge
  always @(negedge clk_sys) begin
    if (rx_valid)    obs_rx.push_back('{kind: R_VALID,   val: rx_byte, cyc: cyc});
    if (err_parity)  obs_rx.push_back('{kind: R_PARITY,  val: rx_byte, cyc: cyc});
    if (err_frame)   obs_rx.push_back('{kind: R_FRAME,   val: rx_byte, cyc: cyc});
    if (err_timeout) obs_rx.push_back('{kind: R_TIMEOUT, val: rx_byte, cyc: cyc});
    if (key_strobe)  obs_key.push_back('{code: key_code, ext: key_ext, pressed: key_pressed, cyc: cyc});
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic       m_ext = 1'b0, m_rel = 1'b0;
  logic [7:0] m_byte = 8'h00, m_code = 8'h00;
  logic       m_kext = 1'b0, m_kpr = 1'b0;

  function automatic res_e ref_result(input logic [7:0] d, input logic par, input logic stop);
    if (!stop) return R_FRAME;
    if (($countones({d, par}) % 2) == 1) return R_VALID;
    return R_PARITY;
  endfunction

  task automatic mdl_apply(input res_e kind, input logic [7:0] d, output logic key_ev);
    key_ev = 1'b0;
    if (kind == R_VALID) begin
      m_byte = d;
      if (d == 8'hE0) m_ext = 1'b1;
      else if (d == 8'hF0) m_rel = 1'b1;
      else begin
        m_code = d; m_kext = m_ext; m_kpr = !m_rel;
        m_ext = 1'b0; m_rel = 1'b0;
        key_ev = 1'b1;
      end
    end
  endtask

  task automatic mdl_reset();
    m_ext = 1'b0; m_rel = 1'b0; m_byte = 8'h00;
    m_code = 8'h00; m_kext = 1'b0; m_kpr = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  // Emulator timing: data changes at the start of the high phase, clock low for div cycles
  task automatic send_bits(input logic [10:0] bits, input int nbits, input int div,
                           input int glitch_bit, output int t_last);
    t_last = cyc;
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      if (i == glitch_bit) begin
        tick(div / 2);
        ps2_clk = 1'b0;
        tick(2);
        ps2_clk = 1'b1;
        tick(div - div / 2);
      end else begin
        tick(div);
      end
      ps2_clk = 1'b0;
      t_last  = cyc;
      tick(div);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic check_result(input string name, input res_e kind, input int t_ref, input int lat,
                              input logic [7:0] exp_rx, input logic exp_key, input logic [7:0] exp_code,
                              input logic exp_ext, input logic exp_pr);
    rx_ev_t  e;
    key_ev_t k;
    e = '{kind: R_VALID, val: 8'h00, cyc: 0};
    check({name, " result count"}, obs_rx.size(), 1);
    if (obs_rx.size() > 0) begin
      e = obs_rx.pop_front();
      check({name, " result kind"}, e.kind, kind);
      check({name, " result latency"}, e.cyc - t_ref, lat);
      if (kind == R_VALID) check({name, " strobed byte"}, e.val, exp_rx);
    end
    check({name, " key count"}, obs_key.size(), exp_key ? 1 : 0);
    if (exp_key && obs_key.size() > 0) begin
      k = obs_key.pop_front();
      check({name, " key_code"}, k.code, exp_code);
      check({name, " key_ext"}, k.ext, exp_ext);
      check({name, " key_pressed"}, k.pressed, exp_pr);
      check({name, " key delay"}, k.cyc - e.cyc, 1);
    end
    check({name, " held rx_byte"}, rx_byte, exp_rx);
    check({name, " held key"}, {key_code, key_ext, key_pressed}, {exp_code, exp_ext, exp_pr});
    obs_rx.delete();
    obs_key.delete();
  endtask

  task automatic send_and_check(input string name, input logic [7:0] d, input logic par,
                                input logic stop, input int div, input int glitch_bit);
    int   t;
    res_e kind;
    logic kev;
    send_bits({stop, par, d, 1'b0}, 11, div, glitch_bit, t);
    kind = ref_result(d, par, stop);
    mdl_apply(kind, d, kev);
    check_result(name, kind, t, LAT, m_byte, kev, m_code, m_kext, m_kpr);
  endtask

  task automatic wait_result(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (obs_rx.size() != 0) break;
      tick(1);
    end
  endtask

  vec_t vecs[14];

  initial begin
    int         t;
    logic       kev;
    logic [7:0] d;
    logic       par, stop;

    vecs[0]  = '{8'h1C, 1'b0, 1'b1, 1000, R_VALID,  8'h1C, 1'b1, 8'h1C, 1'b0, 1'b1};
    vecs[1]  = '{8'hE0, 1'b0, 1'b1, 25,   R_VALID,  8'hE0, 1'b0, 8'h1C, 1'b0, 1'b1};
    vecs[2]  = '{8'hF0, 1'b1, 1'b1, 25,   R_VALID,  8'hF0, 1'b0, 8'h1C, 1'b0, 1'b1};
    vecs[3]  = '{8'h75, 1'b0, 1'b1, 25,   R_VALID,  8'h75, 1'b1, 8'h75, 1'b1, 1'b0};
    vecs[4]  = '{8'h1C, 1'b1, 1'b1, 25,   R_PARITY, 8'h75, 1'b0, 8'h75, 1'b1, 1'b0};
    vecs[5]  = '{8'h5A, 1'b1, 1'b0, 25,   R_FRAME,  8'h75, 1'b0, 8'h75, 1'b1, 1'b0};
    vecs[6]  = '{8'h29, 1'b0, 1'b1, 25,   R_VALID,  8'h29, 1'b1, 8'h29, 1'b0, 1'b1};
    vecs[7]  = '{8'h33, 1'b0, 1'b0, 25,   R_FRAME,  8'h29, 1'b0, 8'h29, 1'b0, 1'b1};
    vecs[8]  = '{8'hF0, 1'b1, 1'b1, 30,   R_VALID,  8'hF0, 1'b0, 8'h29, 1'b0, 1'b1};
    vecs[9]  = '{8'hF0, 1'b1, 1'b1, 30,   R_VALID,  8'hF0, 1'b0, 8'h29, 1'b0, 1'b1};
    vecs[10] = '{8'h1C, 1'b1, 1'b1, 30,   R_PARITY, 8'hF0, 1'b0, 8'h29, 1'b0, 1'b1};
    vecs[11] = '{8'hE0, 1'b0, 1'b1, 30,   R_VALID,  8'hE0, 1'b0, 8'h29, 1'b0, 1'b1};
    vecs[12] = '{8'hE0, 1'b0, 1'b1, 30,   R_VALID,  8'hE0, 1'b0, 8'h29, 1'b0, 1'b1};
    vecs[13] = '{8'h12, 1'b1, 1'b1, 30,   R_VALID,  8'h12, 1'b1, 8'h12, 1'b1, 1'b0};

    // Reset state
    tick(3);
    check("reset outputs",
          {rx_byte, key_code, key_ext, key_pressed, busy, rx_valid, err_parity, err_frame, err_timeout, key_strobe},
          32'h0);
    reset_n = 1'b1;
    tick(5);

    // Table-driven frames
    foreach (vecs[i]) begin
      send_bits({vecs[i].stop, vecs[i].par, vecs[i].data, 1'b0}, 11, vecs[i].div, -1, t);
      mdl_apply(vecs[i].kind, vecs[i].data, kev);
      check_result($sformatf("vec%0d", i), vecs[i].kind, t, LAT, vecs[i].rx,
                   vecs[i].key, vecs[i].code, vecs[i].ext, vecs[i].pressed);
    end

    // Start bit 1 seen in idle
    send_bits(11'h7FF, 1, 25, -1, t);
    check_result("idle start1", R_FRAME, t, LAT, m_byte, 1'b0, m_code, m_kext, m_kpr);

    // Watchdog abort after 5 bits; the E0 flag survives it
    send_and_check("pre-timeout E0", 8'hE0, 1'b0, 1'b1, 25, -1);
    send_bits({1'b1, 1'b0, 8'h75, 1'b0}, 5, 25, -1, t);
    check("busy mid-frame", busy, 1'b1);
    wait_result(TIMEOUT + 100);
    check_result("timeout", R_TIMEOUT, t, LAT + TIMEOUT, m_byte, 1'b0, m_code, m_kext, m_kpr);
    check("busy after timeout", busy, 1'b0);
    send_and_check("post-timeout 75", 8'h75, 1'b0, 1'b1, 25, -1);

    // Short clock glitches: idle one must not sample, mid-frame one must not shift
    ps2_data = 1'b1;
    tick(10);
    ps2_clk = 1'b0;
    tick(2);
    ps2_clk = 1'b1;
    tick(30);
    check("idle glitch events", obs_rx.size(), 0);
    check("idle glitch busy", busy, 1'b0);
    send_and_check("glitched 29", 8'h29, 1'b0, 1'b1, 30, 4);

    // Reset in the middle of a frame, with the release flag pending
    send_and_check("pre-reset F0", 8'hF0, 1'b1, 1'b1, 25, -1);
    send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 6, 25, -1, t);
    reset_n = 1'b0;
    tick(2);
    check("mid-frame reset outputs",
          {rx_byte, key_code, key_ext, key_pressed, busy, rx_valid, err_parity, err_frame, err_timeout, key_strobe},
          32'h0);
    reset_n  = 1'b1;
    ps2_data = 1'b1;
    mdl_reset();
    tick(TIMEOUT + 50);
    check("post-reset silent results", obs_rx.size(), 0);
    check("post-reset silent keys", obs_key.size(), 0);
    send_and_check("post-reset 1C", 8'h1C, 1'b0, 1'b1, 25, -1);

    // Randomized back-to-back frames against the model
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 7))
        0, 1:    d = 8'hE0;
        2, 3:    d = 8'hF0;
        default: d = 8'($urandom);
      endcase
      par  = (($countones(d) % 2) == 0);
      if ($urandom_range(0, 7) == 0) par = ~par;
      stop = ($urandom_range(0, 7) != 0);
      send_and_check($sformatf("rand%0d", n), d, par, stop, $urandom_range(25, 40), -1);
    end

    tick(20);
    check("trailing results", obs_rx.size(), 0);
    check("trailing keys", obs_key.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute bound on the run
  initial begin
    #1500000;
    $display("FAIL global time limit: got no summary expected summary");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/ps2_host_rx.md
Name: ps2_host_rx

Overview:
Core-side PS/2 receiver. It deserialises the keyboard clock/data pair driven by the HPS bridge's PS/2 emulation. Frames are 11 bits, data is sampled on the falling clock edge, and parity is odd. Each validated byte is passed on, and a scancode layer merges E0/F0 prefixes into key events for the core's keyboard matrix logic.

Parameters:
FILTER, 4, consecutive identical synchronised samples required before the filtered ps2_clk/ps2_data level changes (1..15).
TIMEOUT, 8191, clk_sys cycles allowed between falling edges inside a frame before the frame is aborted. Must exceed the 2*PS2DIV bit period.

Ports:
clk_sys      in   1  system clock
reset_n      in   1  synchronous reset, active-low
ps2_clk      in   1  PS/2 clock from emulator, asynchronous, idle high
ps2_data     in   1  PS/2 data from emulator, asynchronous, idle high
rx_byte      out  8  last validated byte
rx_valid     out  1  1-cycle strobe: rx_byte updated
err_parity   out  1  1-cycle strobe: parity mismatch, byte discarded
err_frame    out  1  1-cycle strobe: start bit 1 or stop bit 0, byte discarded
err_timeout  out  1  1-cycle strobe: frame aborted by watchdog
busy         out  1  frame in progress (bit counter nonzero)
key_code     out  8  scancode of last key event
key_ext      out  1  event was preceded by E0
key_pressed  out  1  1 = make, 0 = break (F0 seen)
key_strobe   out  1  1-cycle strobe: key_* updated

Behaviour:
- Reset (reset_n=0 at a clk_sys edge): every output is 0. Bit counter, watchdog, ext/rel flags and shift register are cleared. Filtered levels are set to 1.
- Input path: 2-FF synchroniser per line, then a saturating counter filter. The filtered level flips only after FILTER equal samples that differ from the current level.
- Falling edge: filtered clk was 1 on the previous cycle and is 0 now. This is the only sampling event, and filtered data is sampled on that cycle.
- States: IDLE, bit count 0. SHIFT, counts 1..9. STOP, count 10.
  - IDLE: on a falling edge, if data=0 go to count 1. If data=1, pulse err_frame and stay IDLE.
  - SHIFT: counts 1..8 shift data in LSB-first. Count 9 latches the parity bit.
  - STOP: on a falling edge, check stop=1 and odd parity over 8 data bits plus the parity bit. Return to IDLE.
- Result: on the cycle after the stop-bit edge, exactly one of rx_valid, err_parity or err_frame is high. Stop bit 0 gives err_frame, even when parity is also bad.
- Watchdog: cleared on each falling edge and counts while busy. When it reaches TIMEOUT, pulse err_timeout next cycle, return to IDLE and discard partial data. The ext/rel flags are kept.
- Scancode layer, evaluated on rx_valid:
  - E0 sets ext.
  - F0 sets rel.
  - Any other byte raises key_strobe the next cycle, i.e. 2 cycles after the stop edge. It loads key_code=byte, key_ext=ext, key_pressed=~rel, then clears both flags.
  - A repeated prefix is idempotent.
  - Errors do not touch the flags.
- key_* and rx_byte hold their value between strobes.
- Reset mid-frame: the frame is dropped silently, with no error strobe.
- Back-to-back frames: the next start bit may arrive one bit period after the stop bit, so no idle gap is required.

Decomposition:
- Package ps2_pkg: PS2_PREFIX_EXT=8'hE0, PS2_PREFIX_REL=8'hF0, PS2_FRAME_BITS=11, and a state enum {IDLE, SHIFT, STOP}.
- Sub-module ps2_rx_filter: synchroniser plus glitch filter. Instantiate it once per line, parameterised by FILTER.

Test Plan:
- Emit 0x1C frame (data 0,0,0,1,1,1,0,0; parity 0; stop 1) at PS2DIV=1000 -> rx_valid once, rx_byte=0x1C; key_strobe next cycle with key_code=0x1C, key_ext=0, key_pressed=1.
- Frames E0, F0, 75 (parity 0, 1, 0) -> three rx_valid pulses; a single key_strobe with key_code=0x75, key_ext=1, key_pressed=0; both flags cleared afterwards.
- 0x1C sent with parity bit 1 -> err_parity once, no rx_valid, no key_strobe, rx_byte unchanged.
- Frame with stop bit 0 -> err_frame once; the following valid 0x29 frame still yields rx_valid with 0x29.
- Clock held high after 5 bits -> err_timeout exactly TIMEOUT+1 cycles after the last falling edge; busy drops; next full frame decodes correctly.
- 2-cycle low glitch on ps2_clk with FILTER=4 -> no bit sampled, bit counter unchanged. Also: reset_n=0 mid-frame -> all outputs 0, no error strobes, then clean reception.
